// File: rtl/serv_ibus_bridge.sv
`default_nettype none
// ============================================================================
// serv_ibus_bridge
// Lets a Wishbone host answer SERV instruction fetches through a 4-register
// window; a programmable wait limit returns a NOP when the host is too slow.
// Rev 1.0
// ============================================================================
module serv_ibus_bridge #(
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  output logic        o_irq,
  output logic        o_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_ADDR   = 2'd1;
  localparam logic [1:0] OFF_INSTR  = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdt_q, rdt_d;
  logic        ibus_ack_q, ibus_ack_d;
  logic        timeout_q, timeout_d;
  logic        enable_q, enable_d;
  logic [15:0] limit_q, limit_d;

  logic        w_hit, w_req, w_wr, w_rd;
  logic [1:0]  w_off;
  logic        w_instr_wr, w_ctrl_wr;
  logic        w_abort, w_expire, w_capture;
  logic [31:0] w_rdata;
  logic        w_cap_fire, w_host_fire, w_to_fire;
  logic        w_unused_adr;

  assign w_unused_adr = ^wbs_adr_i[1:0];

  // The ack gate keeps back-to-back strobes from being acked on adjacent cycles.
  assign w_hit      = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_req      = wbs_cyc_i & wbs_stb_i & w_hit & ~ack_q;
  assign w_wr       = w_req & wbs_we_i;
  assign w_rd       = w_req & ~wbs_we_i;
  assign w_off      = wbs_adr_i[3:2];
  assign w_instr_wr = w_wr & (w_off == OFF_INSTR) & (wbs_sel_i == 4'hF);
  assign w_ctrl_wr  = w_wr & (w_off == OFF_CTRL);

  assign w_abort    = ~i_ibus_cyc | ~enable_q;
  assign w_expire   = (limit_q != 16'h0000) & (cnt_q == limit_q);
  // SERV still holds cyc while it sees the ack; don't mistake that for a new fetch.
  assign w_capture  = enable_q & i_ibus_cyc & ~ibus_ack_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_capture) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (w_abort)         state_d = S_IDLE;
        else if (w_instr_wr) state_d = S_RESP;
        else if (w_expire)   state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_irq       = (state_q == S_WAIT);
    w_cap_fire  = (state_q == S_IDLE) & w_capture;
    w_host_fire = (state_q == S_WAIT) & ~w_abort & w_instr_wr;
    w_to_fire   = (state_q == S_WAIT) & ~w_abort & ~w_instr_wr & w_expire;
  end

  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      OFF_STATUS: w_rdata = {30'h0, timeout_q, (state_q == S_WAIT)};
      OFF_ADDR:   w_rdata = addr_q;
      OFF_INSTR:  w_rdata = 32'h0;
      OFF_CTRL:   w_rdata = {limit_q, 15'h0, enable_q};
      default:    w_rdata = 32'h0;
    endcase
  end

  always_comb begin
    ack_d      = w_req;
    dat_d      = w_rd ? w_rdata : 32'h0;
    ibus_ack_d = (state_q == S_RESP);
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rdt_d      = rdt_q;
    enable_d   = enable_q;
    limit_d    = limit_q;
    timeout_d  = timeout_q;

    if (w_cap_fire) begin
      addr_d = i_ibus_adr;
      cnt_d  = 16'h0000;
    end else if ((state_q == S_WAIT) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (w_host_fire)    rdt_d = wbs_dat_i;
    else if (w_to_fire) rdt_d = NOP_INSTR;

    if (w_ctrl_wr) begin
      if (wbs_sel_i[0]) enable_d      = wbs_dat_i[0];
      if (wbs_sel_i[2]) limit_d[7:0]  = wbs_dat_i[23:16];
      if (wbs_sel_i[3]) limit_d[15:8] = wbs_dat_i[31:24];
    end

    // A timeout firing in the same cycle as a clear request must stay visible.
    if (w_to_fire)                                   timeout_d = 1'b1;
    else if (w_ctrl_wr && wbs_sel_i[0] && wbs_dat_i[1]) timeout_d = 1'b0;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      addr_q     <= 32'h0;
      cnt_q      <= 16'h0000;
      rdt_q      <= 32'h0;
      ibus_ack_q <= 1'b0;
      timeout_q  <= 1'b0;
      enable_q   <= 1'b0;
      limit_q    <= 16'h0000;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rdt_q      <= rdt_d;
      ibus_ack_q <= ibus_ack_d;
      timeout_q  <= timeout_d;
      enable_q   <= enable_d;
      limit_q    <= limit_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign o_ibus_rdt = rdt_q;
  assign o_ibus_ack = ibus_ack_q;
  assign o_timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_serv_ibus_bridge.sv
`default_nettype none
// Self-checking bench for serv_ibus_bridge: directed scenarios followed by
// random host/core traffic compared against a transaction-level model.
module tb_serv_ibus_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] A_STATUS = BASE + 32'h0;
  localparam logic [31:0] A_ADDR   = BASE + 32'h4;
  localparam logic [31:0] A_INSTR  = BASE + 32'h8;
  localparam logic [31:0] A_CTRL   = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'h0;
  logic [31:0] wb_adr = 32'h0, wb_dat = 32'h0;
  logic        wb_ack;
  logic [31:0] wb_rdat;
  logic [31:0] ib_adr = 32'h0;
  logic        ib_cyc = 1'b0;
  logic [31:0] ib_rdt;
  logic        ib_ack, irq, tmo;

  int n_checks = 0;
  int n_fail   = 0;

  // Core-side stimulus persists across host transactions.
  logic        core_cyc = 1'b0;
  logic [31:0] core_adr = 32'h0;

  // Reference model: what the bridge should be showing after each edge.
  logic        m_pend, m_answer, m_iack, m_en, m_to, m_ack;
  logic [15:0] m_lim, m_cnt;
  logic [31:0] m_addr, m_rdt, m_dat;

  serv_ibus_bridge #(.BASE_ADR(BASE), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .i_rst_n   (rst_n),
    .wbs_cyc_i (wb_cyc),
    .wbs_stb_i (wb_stb),
    .wbs_we_i  (wb_we),
    .wbs_sel_i (wb_sel),
    .wbs_adr_i (wb_adr),
    .wbs_dat_i (wb_dat),
    .wbs_ack_o (wb_ack),
    .wbs_dat_o (wb_rdat),
    .i_ibus_adr(ib_adr),
    .i_ibus_cyc(ib_cyc),
    .o_ibus_rdt(ib_rdt),
    .o_ibus_ack(ib_ack),
    .o_irq     (irq),
    .o_timeout (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_answer = 0; m_iack = 0; m_en = 0; m_to = 0; m_ack = 0;
    m_lim = 0; m_cnt = 0; m_addr = 0; m_rdt = 0; m_dat = 0;
  endtask

  // Advance the model across one rising edge given the inputs now applied.
  task automatic model_step();
    logic        req, instr_ok, ctrl_w, set_to, clr_to;
    logic [31:0] rd;
    logic        n_pend, n_answer;
    logic [15:0] n_cnt, n_lim;
    logic [31:0] n_addr, n_rdt;
    logic        n_en;
    req      = wb_cyc && wb_stb && (wb_adr[31:4] == BASE[31:4]) && !m_ack;
    instr_ok = req && wb_we && (wb_adr[3:2] == 2'd2) && (wb_sel == 4'hF);
    ctrl_w   = req && wb_we && (wb_adr[3:2] == 2'd3);
    case (wb_adr[3:2])
      2'd0:    rd = {30'h0, m_to, m_pend};
      2'd1:    rd = m_addr;
      2'd3:    rd = {m_lim, 15'h0, m_en};
      default: rd = 32'h0;
    endcase
    n_pend = m_pend; n_answer = 1'b0; n_cnt = m_cnt; n_addr = m_addr;
    n_rdt = m_rdt; n_en = m_en; n_lim = m_lim; set_to = 1'b0; clr_to = 1'b0;
    if (m_pend) begin
      if (!ib_cyc || !m_en) n_pend = 1'b0;
      else if (instr_ok) begin
        n_pend = 1'b0; n_answer = 1'b1; n_rdt = wb_dat;
      end else if (m_lim != 0 && m_cnt == m_lim) begin
        n_pend = 1'b0; n_answer = 1'b1; n_rdt = NOP; set_to = 1'b1;
      end else if (m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
    end else if (!m_answer && !m_iack && m_en && ib_cyc) begin
      n_pend = 1'b1; n_cnt = 16'h0; n_addr = ib_adr;
    end
    if (ctrl_w) begin
      if (wb_sel[0]) begin n_en = wb_dat[0]; clr_to = wb_dat[1]; end
      if (wb_sel[2]) n_lim[7:0]  = wb_dat[23:16];
      if (wb_sel[3]) n_lim[15:8] = wb_dat[31:24];
    end
    m_to     = set_to ? 1'b1 : (clr_to ? 1'b0 : m_to);
    m_dat    = (req && !wb_we) ? rd : 32'h0;
    m_ack    = req;
    m_iack   = m_answer;
    m_answer = n_answer;
    m_pend   = n_pend; m_cnt = n_cnt; m_addr = n_addr; m_rdt = n_rdt;
    m_en     = n_en;   m_lim = n_lim;
  endtask

  task automatic check_all();
    chk("wb_ack",  32'(wb_ack), 32'(m_ack));
    chk("wb_dat",  wb_rdat, m_dat);
    chk("ib_rdt",  ib_rdt, m_rdt);
    chk("ib_ack",  32'(ib_ack), 32'(m_iack));
    chk("irq",     32'(irq), 32'(m_pend));
    chk("timeout", 32'(tmo), 32'(m_to));
  endtask

  task automatic tick(input logic c, input logic s, input logic w, input logic [3:0] sel,
                      input logic [31:0] a, input logic [31:0] d);
    wb_cyc = c; wb_stb = s; wb_we = w; wb_sel = sel; wb_adr = a; wb_dat = d;
    ib_cyc = core_cyc; ib_adr = core_adr;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic hw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    tick(1'b1, 1'b1, 1'b1, sel, a, d);
    idle();
  endtask

  task automatic hr(input logic [31:0] a, output logic [31:0] d);
    tick(1'b1, 1'b1, 1'b0, 4'hF, a, 32'h0);
    d = wb_rdat;
    idle();
  endtask

  task automatic wait_iack(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      idle();
      seen = ib_ack;
    end
    chk(tag, 32'(seen), 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    int          acks;
    logic        c, s, w;
    logic [3:0]  sel;
    logic [31:0] a, d;
    int          r;

    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Host-served fetch.
    hw(A_CTRL, 32'h0000_0001, 4'hF);
    core_cyc = 1'b1; core_adr = 32'h0000_0100;
    idle();
    chk("irq_pending", 32'(irq), 32'h1);
    hr(A_ADDR, rd);
    chk("addr_read", rd, 32'h0000_0100);
    tick(1'b1, 1'b1, 1'b1, 4'hF, A_INSTR, 32'h0010_0093);
    wait_iack("host_iack");
    chk("host_rdt", ib_rdt, 32'h0010_0093);
    chk("host_irq_low", 32'(irq), 32'h0);
    core_cyc = 1'b0;
    idle();
    chk("iack_one_cycle", 32'(ib_ack), 32'h0);

    // Timeout with limit 4.
    hw(A_CTRL, 32'h0004_0001, 4'hF);
    core_cyc = 1'b1; core_adr = 32'h0000_0200;
    idle();
    repeat (4) idle();
    idle();
    chk("to_rdt_nop", ib_rdt, NOP);
    chk("to_flag", 32'(tmo), 32'h1);
    wait_iack("to_iack");
    core_cyc = 1'b0;
    idle();
    hr(A_STATUS, rd);
    chk("status_to", rd, 32'h0000_0002);
    hw(A_CTRL, 32'h0000_0002, 4'hF);
    hr(A_STATUS, rd);
    chk("status_cleared", rd, 32'h0000_0000);

    // Host write on the expiry cycle wins.
    hw(A_CTRL, 32'h0004_0001, 4'hF);
    core_cyc = 1'b1; core_adr = 32'h0000_0300;
    idle();
    repeat (4) idle();
    tick(1'b1, 1'b1, 1'b1, 4'hF, A_INSTR, 32'hABCD_0013);
    chk("race_rdt", ib_rdt, 32'hABCD_0013);
    chk("race_no_to", 32'(tmo), 32'h0);
    wait_iack("race_iack");
    core_cyc = 1'b0;
    idle();

    // Core abandons the fetch.
    core_cyc = 1'b1; core_adr = 32'h0000_0400;
    idle();
    idle();
    core_cyc = 1'b0;
    idle();
    tick(1'b1, 1'b1, 1'b1, 4'hF, A_INSTR, 32'h1111_2222);
    chk("abort_host_ack", 32'(wb_ack), 32'h1);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      acks += int'(ib_ack);
    end
    chk("abort_no_iack", 32'(acks), 32'h0);
    hr(A_STATUS, rd);
    chk("abort_idle", rd, 32'h0000_0000);

    // Miss is ignored; partial INSTR write is acked but leaves fetch pending.
    hw(A_CTRL, 32'h0000_0001, 4'hF);
    core_cyc = 1'b1; core_adr = 32'h0000_0500;
    idle();
    tick(1'b1, 1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
    chk("miss_no_ack", 32'(wb_ack), 32'h0);
    idle();
    tick(1'b1, 1'b1, 1'b1, 4'h3, A_INSTR, 32'h5555_5555);
    chk("partial_ack", 32'(wb_ack), 32'h1);
    idle();
    chk("partial_pending", 32'(irq), 32'h1);

    // Reset in the middle of a wait.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wb_ack", 32'(wb_ack), 32'h0);
    chk("rst_wb_dat", wb_rdat, 32'h0);
    chk("rst_rdt", ib_rdt, 32'h0);
    chk("rst_iack", 32'(ib_ack), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_to", 32'(tmo), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();
    chk("rst_disabled", 32'(irq), 32'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if (($urandom % 8) == 0) core_cyc = ~core_cyc;
      if (ib_ack && ($urandom % 2) == 0) core_cyc = 1'b0;
      if (!core_cyc) core_adr = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      c = ($urandom % 2) == 0;
      s = ($urandom % 8) != 0;
      w = ($urandom % 2) == 0;
      sel = (($urandom % 4) != 0) ? 4'hF : 4'($urandom);
      r = int'($urandom % 8);
      if (r < 6)       a = BASE + {28'h0, 2'($urandom), 2'b00};
      else if (r == 6) a = BASE + 32'h10;
      else             a = $urandom;
      d = $urandom;
      if (a == A_CTRL) begin
        d[31:16] = 16'($urandom_range(0, 6));
        d[0]     = ($urandom % 5) != 0;
        d[1]     = ($urandom % 4) == 0;
      end
      tick(c, s, w, sel, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
